// File: rtl/byte_cmd_transmitter.sv
// Queues 24-bit address / 32-bit data write commands and serializes each one as an
// 8-byte frame (0x01, address MSB first, data MSB first) under downstream throttling.
module byte_cmd_transmitter #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic        ClkIngress,
  input  logic        ARst,
  input  logic [23:0] WriteAddr,
  input  logic [31:0] WriteData,
  input  logic        WriteValid,
  output logic        WriteReady,
  input  logic        Rdyn,
  output logic [7:0]  Data,
  output logic        DataValid,
  output logic        Busy,
  output logic [15:0] FrameCount
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthC  = CntW'(FIFO_DEPTH);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
  localparam logic [7:0]      GapLast = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

  state_e          r_state;
  state_e          w_state_next;
  logic [55:0]     r_mem [FIFO_DEPTH];
  logic [PtrW-1:0] r_wptr;
  logic [PtrW-1:0] r_rptr;
  logic [CntW-1:0] r_count;
  logic [63:0]     r_frame;
  logic [2:0]      r_idx;
  logic [7:0]      r_gap_cnt;
  logic [7:0]      r_data;
  logic            r_data_valid;
  logic [15:0]     r_frame_count;
  logic            w_push;
  logic            w_pop;
  logic            w_issue;

  // Readiness depends only on the current count: a same-cycle pop never frees a slot.
  assign WriteReady = (r_count < DepthC) && !ARst;
  assign w_push     = WriteValid && WriteReady;
  assign w_pop      = (r_state == StIdle) && (r_count != '0);
  assign w_issue    = (r_state == StSend) && !Rdyn;

  assign Data       = r_data;
  assign DataValid  = r_data_valid;
  assign FrameCount = r_frame_count;
  assign Busy       = (r_count != '0) || (r_state != StIdle);

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: if (r_count != '0) w_state_next = StSend;
      StSend: begin
        if (w_issue && (r_idx == 3'd7)) w_state_next = (GAP_CYCLES > 0) ? StGap : StIdle;
      end
      StGap:  if (r_gap_cnt == GapLast) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge ClkIngress) begin
    if (ARst) r_state <= StIdle;
    else      r_state <= w_state_next;
  end

  always_ff @(posedge ClkIngress) begin
    if (w_push) r_mem[r_wptr] <= {WriteAddr, WriteData};
  end

  always_ff @(posedge ClkIngress) begin
    if (ARst) begin
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
      r_frame       <= '0;
      r_idx         <= '0;
      r_gap_cnt     <= '0;
      r_data        <= '0;
      r_data_valid  <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_data_valid <= 1'b0;
      if (w_push) r_wptr <= r_wptr + PtrOne;
      if (w_pop) begin
        r_frame <= {8'h01, r_mem[r_rptr]};
        r_rptr  <= r_rptr + PtrOne;
        r_idx   <= '0;
      end
      if (w_push && !w_pop)      r_count <= r_count + CntOne;
      else if (w_pop && !w_push) r_count <= r_count - CntOne;
      // Frame shifts out MSB first; Data keeps the last byte while stalled.
      if (w_issue) begin
        r_data       <= r_frame[63:56];
        r_frame      <= {r_frame[55:0], 8'h00};
        r_data_valid <= 1'b1;
        r_idx        <= r_idx + 3'd1;
        if (r_idx == 3'd7) begin
          r_frame_count <= r_frame_count + 16'd1;
          r_gap_cnt     <= '0;
        end
      end
      if (r_state == StGap) r_gap_cnt <= r_gap_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_byte_cmd_transmitter.sv
// Scoreboard bench: writers queue the expected frame bytes, per-DUT monitors pop and compare
// each presented byte and log its cycle; timing is checked from those logs.
module tb_byte_cmd_transmitter;

  logic        clk = 1'b0;
  logic        ARst = 1'b1;
  logic        Rdyn = 1'b0;
  logic        wv = 1'b0;
  logic        wv_g = 1'b0;
  logic [23:0] waddr = '0;
  logic [31:0] wdata = '0;
  logic        wr, dv, busy, wr_g, dv_g, busy_g;
  logic [7:0]  data, data_g;
  logic [15:0] fc, fc_g;

  always #5 clk = ~clk;

  byte_cmd_transmitter #(.FIFO_DEPTH(4), .GAP_CYCLES(0)) dut (
    .ClkIngress(clk), .ARst(ARst), .WriteAddr(waddr), .WriteData(wdata), .WriteValid(wv),
    .WriteReady(wr), .Rdyn(Rdyn), .Data(data), .DataValid(dv), .Busy(busy), .FrameCount(fc)
  );

  byte_cmd_transmitter #(.FIFO_DEPTH(4), .GAP_CYCLES(2)) dut_g (
    .ClkIngress(clk), .ARst(ARst), .WriteAddr(waddr), .WriteData(wdata), .WriteValid(wv_g),
    .WriteReady(wr_g), .Rdyn(Rdyn), .Data(data_g), .DataValid(dv_g), .Busy(busy_g),
    .FrameCount(fc_g)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_g_q[$];
  int st_q[$];
  int st_g_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (dv === 1'b1) begin
      st_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL main_unexpected_byte: got 0x%0h at cycle %0d expected none", data, cyc);
      end else begin
        chk("main_byte", {24'd0, data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (dv_g === 1'b1) begin
      st_g_q.push_back(cyc);
      if (exp_g_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL gap_unexpected_byte: got 0x%0h at cycle %0d expected none", data_g, cyc);
      end else begin
        chk("gap_byte", {24'd0, data_g}, {24'd0, exp_g_q.pop_front()});
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic write_cmd(input bit g, input logic [23:0] a, input logic [31:0] d,
                           output int acc);
    logic [63:0] f;
    logic rdy;
    int c;
    waddr = a;
    wdata = d;
    if (g) wv_g = 1'b1;
    else   wv = 1'b1;
    acc = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      rdy = g ? wr_g : wr;
      c = cyc;
      @(posedge clk);
      if (rdy) begin
        acc = c;
        break;
      end
    end
    #1;
    wv = 1'b0;
    wv_g = 1'b0;
    if (acc < 0) begin
      checks++;
      errors++;
      $display("FAIL write_timeout: got no accept expected accept within 100 cycles");
    end else begin
      f = {8'h01, a, d};
      for (int j = 0; j < 8; j++) begin
        if (g) exp_g_q.push_back(f[63-8*j -: 8]);
        else   exp_q.push_back(f[63-8*j -: 8]);
      end
    end
  endtask

  task automatic drain(input bit g);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if ((g ? exp_g_q.size() : exp_q.size()) == 0) break;
    end
    if ((g ? exp_g_q.size() : exp_q.size()) != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d bytes pending expected 0",
               g ? exp_g_q.size() : exp_q.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  int acc;
  int cd;
  int a6[6];
  int off3[8] = '{3, 4, 5, 9, 10, 11, 12, 13};
  int n;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_data", {24'd0, data}, 32'h0);
    chk("rst_valid", {31'd0, dv}, 32'h0);
    chk("rst_framecount", {16'd0, fc}, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'h0);
    chk("rst_wready", {31'd0, wr}, 32'h0);
    @(posedge clk);
    #1 ARst = 1'b0;
    cd = cyc;

    // Single frame; first push on the first cycle out of reset.
    st_q.delete();
    write_cmd(1'b0, 24'h123456, 32'hDEADBEEF, acc);
    chk("first_push_cycle", acc, cd);
    drain(1'b0);
    chk("t1_nbytes", st_q.size(), 8);
    n = (st_q.size() < 8) ? st_q.size() : 8;
    for (int j = 0; j < n; j++) chk("t1_byte_cycle", st_q[j], acc + 3 + j);
    chk("t1_framecount", {16'd0, fc}, 32'd1);
    chk("t1_busy_idle", {31'd0, busy}, 32'h0);

    // Six back-to-back commands: FIFO fills, then frames stream with a 9-cycle period.
    st_q.delete();
    for (int i = 0; i < 6; i++) write_cmd(1'b0, 24'hA00000 + 24'(i), 32'h1000_0000 * i, a6[i]);
    drain(1'b0);
    chk("t2_accept5", a6[4], a6[0] + 4);
    chk("t2_accept6_after_pop", a6[5], a6[0] + 11);
    chk("t2_nbytes", st_q.size(), 48);
    n = (st_q.size() < 48) ? st_q.size() : 48;
    for (int j = 0; j < n; j++) chk("t2_byte_cycle", st_q[j], a6[0] + 3 + 9 * (j / 8) + j % 8);
    chk("t2_framecount", {16'd0, fc}, 32'd7);

    // Downstream stall for three cycles once byte 2 is presented.
    st_q.delete();
    write_cmd(1'b0, 24'h0F1E2D, 32'h3C4B5A69, acc);
    repeat (4) @(posedge clk);
    #1 Rdyn = 1'b1;
    repeat (3) @(posedge clk);
    #1 Rdyn = 1'b0;
    drain(1'b0);
    chk("t3_nbytes", st_q.size(), 8);
    n = (st_q.size() < 8) ? st_q.size() : 8;
    for (int j = 0; j < n; j++) chk("t3_byte_cycle", st_q[j], acc + off3[j]);
    chk("t3_framecount", {16'd0, fc}, 32'd8);

    // GAP_CYCLES=2 instance: three idle cycles between frames.
    st_g_q.delete();
    write_cmd(1'b1, 24'h55AA55, 32'hCAFEF00D, a6[0]);
    write_cmd(1'b1, 24'h000001, 32'h80000000, a6[1]);
    drain(1'b1);
    chk("t4_nbytes", st_g_q.size(), 16);
    n = (st_g_q.size() < 16) ? st_g_q.size() : 16;
    for (int j = 0; j < n; j++) chk("t4_byte_cycle", st_g_q[j], a6[0] + 3 + 11 * (j / 8) + j % 8);
    chk("t4_framecount", {16'd0, fc_g}, 32'd2);

    // Reset while byte 4 of the first of three frames is presented.
    st_q.delete();
    for (int i = 0; i < 3; i++) write_cmd(1'b0, 24'hBBBB00 + 24'(i), 32'h7777_0000 + i, a6[i]);
    repeat (4) @(posedge clk);
    #1 ARst = 1'b1;
    @(posedge clk);
    #1 ARst = 1'b0;
    chk("t5_bytes_before_rst", st_q.size(), 5);
    exp_q.delete();
    @(negedge clk);
    chk("t5_valid_after_rst", {31'd0, dv}, 32'h0);
    chk("t5_framecount_rst", {16'd0, fc}, 32'h0);
    chk("t5_wready_after_rst", {31'd0, wr}, 32'h1);
    chk("t5_busy_after_rst", {31'd0, busy}, 32'h0);
    chk("t5_gap_framecount_rst", {16'd0, fc_g}, 32'h0);
    repeat (20) @(posedge clk);
    #1;
    st_q.delete();
    write_cmd(1'b0, 24'hFEDCBA, 32'h01234567, acc);
    drain(1'b0);
    chk("t5_nbytes_new", st_q.size(), 8);
    chk("t5_framecount_new", {16'd0, fc}, 32'd1);

    // Frame counter wrap from a preset 0xFFFF.
    force dut.r_frame_count = 16'hFFFF;
    #2 release dut.r_frame_count;
    @(negedge clk);
    chk("t6_preset", {16'd0, fc}, 32'h0000FFFF);
    @(posedge clk);
    #1;
    write_cmd(1'b0, 24'h0000FF, 32'hFFFFFFFF, acc);
    drain(1'b0);
    chk("t6_wrap", {16'd0, fc}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: got no completion expected finish before 1 ms");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

endmodule
